load_store_unit: RTL and testbench

// Memory-access stage fed by the decode/execute pipeline register (address = registered iadder, store data = registered rs2, load_size/load_unsigned).

---
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// The LSU holds dmem_req_out high until dmem_ack_in. Read data is valid with the ack.
interface load_store_unit_if;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wmask_out;
  logic [31:0] dmem_rdata_in;
  logic        dmem_ack_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
    input  dmem_rdata_in, dmem_ack_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
    output dmem_rdata_in, dmem_ack_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage. It runs one bus transaction for each load or store, stalls
// the pipeline while that transaction is in flight, and returns the extended load
// result. Misaligned or illegal accesses never reach the bus.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic              load_in,
  input  logic              store_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       store_data_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  output logic              stall_out,
  load_store_unit_if.master dmem,
  output logic [31:0]       load_data_out,
  output logic              load_valid_out,
  output logic              store_done_out,
  output logic              misaligned_out,
  output logic              bus_err_out
);
  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  REQ     = 2'd1;
  localparam logic [1:0]  DONE    = 2'd2;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] to_cnt;
  logic        op_load, op_uns;
  logic [1:0]  op_size, op_lane;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;

  logic        accept, aligned;
  logic [3:0]  mask_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ext_data;

  assign accept    = (state == IDLE) & valid_in & (load_in | store_in);
  assign stall_out = (accept & aligned) | (state == REQ);

  // The bus outputs come from registers captured at accept, so they stay constant during REQ.
  assign dmem.dmem_req_out   = (state == REQ);
  assign dmem.dmem_we_out    = we_q;
  assign dmem.dmem_addr_out  = addr_q;
  assign dmem.dmem_wdata_out = wdata_q;
  assign dmem.dmem_wmask_out = wmask_q;

  // Natural-alignment check. Size 11 and simultaneous load+store are treated as illegal.
  always_comb begin
    aligned = 1'b0;
    case (load_size_in)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_in[0];
      2'b10:   aligned = (addr_in[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    if (load_in & store_in) aligned = 1'b0;
  end

  // Byte-lane enables and store-data replication. A read gets an empty mask.
  always_comb begin
    mask_nxt  = 4'b1111;
    wdata_nxt = store_data_in;
    case (load_size_in)
      2'b00: begin
        mask_nxt  = 4'b0001 << addr_in[1:0];
        wdata_nxt = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        mask_nxt  = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{store_data_in[15:0]}};
      end
      default: ;
    endcase
    if (!store_in) mask_nxt = 4'b0000;
  end

  // Select the addressed lane of the read data, then sign- or zero-extend it.
  always_comb begin
    case (op_lane)
      2'd0:    ld_byte = dmem.dmem_rdata_in[7:0];
      2'd1:    ld_byte = dmem.dmem_rdata_in[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata_in[23:16];
      default: ld_byte = dmem.dmem_rdata_in[31:24];
    endcase
    ld_half = op_lane[1] ? dmem.dmem_rdata_in[31:16] : dmem.dmem_rdata_in[15:0];
    case (op_size)
      2'b00:   ext_data = {{24{~op_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ext_data = {{16{~op_uns & ld_half[15]}}, ld_half};
      default: ext_data = dmem.dmem_rdata_in;
    endcase
  end

  // FSM IDLE -> REQ -> DONE -> IDLE. Status pulses are registered, so each one is high for exactly the DONE cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      to_cnt         <= '0;
      op_load        <= 1'b0;
      op_uns         <= 1'b0;
      op_size        <= 2'b00;
      op_lane        <= 2'b00;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      load_data_out  <= '0;
      load_valid_out <= 1'b0;
      store_done_out <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      store_done_out <= 1'b0;
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (aligned) begin
              state   <= REQ;
              to_cnt  <= '0;
              op_load <= load_in;
              op_uns  <= load_unsigned_in;
              op_size <= load_size_in;
              op_lane <= addr_in[1:0];
              we_q    <= store_in;
              addr_q  <= {addr_in[31:2], 2'b00};
              wdata_q <= wdata_nxt;
              wmask_q <= mask_nxt;
            end else begin
              misaligned_out <= 1'b1;
            end
          end
        end
        REQ: begin
          // An ack in the final allowed cycle still completes normally.
          if (dmem.dmem_ack_in) begin
            state          <= DONE;
            load_valid_out <= op_load;
            store_done_out <= ~op_load;
            if (op_load) load_data_out <= ext_data;
          end else if (to_cnt == TO_LAST) begin
            state          <= DONE;
            bus_err_out    <= 1'b1;
            load_valid_out <= op_load;
            store_done_out <= ~op_load;
            if (op_load) load_data_out <= '0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a table of directed vectors, randomized ops checked
// against an arithmetic reference model, and hand sequences for ack-outside-REQ,
// idle valid, asynchronous reset during REQ, and ack timeout.
module tb_load_store_unit;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0, valid_to = 1'b0;
  logic        load_in = 1'b0, store_in = 1'b0, load_unsigned_in = 1'b0;
  logic [31:0] addr_in = '0, store_data_in = '0;
  logic [1:0]  load_size_in = '0;
  logic        stall_out, load_valid_out, store_done_out, misaligned_out, bus_err_out;
  logic [31:0] load_data_out;
  logic        stall_to, lv_to, sd_to, mis_to, err_to;
  logic [31:0] ld_to;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] last_load = '0;

  load_store_unit_if bus();
  load_store_unit_if bus_to();

  load_store_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .load_in(load_in),
    .store_in(store_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .stall_out(stall_out), .dmem(bus.master), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .store_done_out(store_done_out),
    .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
  );

  // Second instance with a short timeout. It only ever sees valid_to.
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_to), .load_in(load_in),
    .store_in(store_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .stall_out(stall_to), .dmem(bus_to.master), .load_data_out(ld_to),
    .load_valid_out(lv_to), .store_done_out(sd_to),
    .misaligned_out(mis_to), .bus_err_out(err_to)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        ld, st;
    logic [31:0] a, d;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] rd;
    int          wt;
    logic        ok;
    logic [3:0]  msk;
    logic [31:0] wd, ld_exp;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: natural alignment, lane mask, replication, extraction.
  function automatic logic aligned_m(input logic ld, input logic st, input logic [1:0] sz,
                                     input logic [31:0] a);
    if ((ld && st) || sz == 2'd3) return 1'b0;
    return (a % (32'd1 << sz)) == 32'd0;
  endfunction

  function automatic logic [3:0] mask_m(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = 1 << sz;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] wdata_m(input logic [1:0] sz, input logic [31:0] d);
    int n;
    longint unsigned piece, acc;
    n = 1 << sz;
    acc = 0;
    piece = {32'd0, d} % (64'd1 << (8 * n));
    for (int k = 0; k < 4 / n; k++) acc += piece << (8 * n * k);
    return acc[31:0];
  endfunction

  function automatic logic [31:0] load_m(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    longint unsigned lim, v;
    lim = 64'd1 << (8 * (1 << sz));
    v = ({32'd0, rd} >> (8 * (a % 4))) % lim;
    if (!uns && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  // Drive one op on the main DUT. The memory model acks after wt wait cycles in REQ.
  task automatic run_op(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic uns, input logic [31:0] rd, input int wt,
                        input logic ok, input logic [3:0] msk, input logic [31:0] wd,
                        input logic [31:0] ld_exp);
    int stalls;
    @(negedge clk_in);
    valid_in = 1'b1; load_in = ld; store_in = st; addr_in = a;
    store_data_in = d; load_size_in = sz; load_unsigned_in = uns;
    #1 chk("stall_at_accept", stall_out, ok);
    @(negedge clk_in);
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
    if (!ok) begin
      chk("misaligned_pulse", misaligned_out, 1'b1);
      chk("misaligned_no_req", bus.dmem_req_out, 1'b0);
      chk("misaligned_no_stall", stall_out, 1'b0);
      @(negedge clk_in);
      chk("misaligned_one_cycle", misaligned_out, 1'b0);
      chk("misaligned_still_no_req", bus.dmem_req_out, 1'b0);
      return;
    end
    stalls = 1;
    for (int i = 0; i <= wt; i++) begin
      chk("req_held", bus.dmem_req_out, 1'b1);
      if (i == 0) begin
        chk("bus_addr", bus.dmem_addr_out, {a[31:2], 2'b00});
        chk("bus_we", bus.dmem_we_out, st);
        chk("bus_wmask", bus.dmem_wmask_out, msk);
        if (st) chk("bus_wdata", bus.dmem_wdata_out, wd);
      end
      if (stall_out) stalls++;
      if (i == wt) begin
        bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = rd;
      end
      @(negedge clk_in);
      bus.dmem_ack_in = 1'b0; bus.dmem_rdata_in = $urandom;
    end
    chk("stall_cycles", stalls, wt + 2);
    chk("done_load_valid", load_valid_out, ld);
    chk("done_store_done", store_done_out, st);
    chk("done_no_bus_err", bus_err_out, 1'b0);
    chk("done_req_low", bus.dmem_req_out, 1'b0);
    chk("done_stall_low", stall_out, 1'b0);
    chk("load_data", load_data_out, ld_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n;
    bus.dmem_ack_in = 1'b0; bus.dmem_rdata_in = '0;
    bus_to.dmem_ack_in = 1'b0; bus_to.dmem_rdata_in = '0;

    //          ld    st    addr          data          sz  uns   rdata         wt ok    msk      wdata         load_data
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd0, 1'b0, 32'h0,         0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_1001, 32'h0,         2'd0, 1'b0, 32'h0000_8000, 0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF80};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_1001, 32'h0,         2'd0, 1'b1, 32'h0000_8000, 1, 1'b1, 4'b0000, 32'h0,         32'h0000_0080};
    // ack arrives 5 cycles after accept: 6 stall cycles
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_2002, 32'h0,         2'd1, 1'b0, 32'h8123_0000, 4, 1'b1, 4'b0000, 32'h0,         32'hFFFF_8123};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'd1, 1'b0, 32'h0,         0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_8123};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,         2, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_8123};
    tbl[6]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         2'd1, 1'b1, 32'h1234_8765, 2, 1'b1, 4'b0000, 32'h0,         32'h0000_8765};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_3002, 32'h0,         2'd2, 1'b0, 32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h0000_8765};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_1001, 32'h0000_FFFF, 2'd1, 1'b0, 32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h0000_8765};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         2'd3, 1'b0, 32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h0000_8765};
    tbl[10] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0,         2'd2, 1'b0, 32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h0000_8765};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_5000, 32'h0,         2'd2, 1'b0, 32'hCAFE_F00D, 0, 1'b1, 4'b0000, 32'h0,         32'hCAFE_F00D};
    tbl[12] = '{1'b0, 1'b1, 32'h0000_6001, 32'h0000_0077, 2'd0, 1'b0, 32'h0,         3, 1'b1, 4'b0010, 32'h7777_7777, 32'hCAFE_F00D};
    tbl[13] = '{1'b1, 1'b0, 32'h0000_6002, 32'h0,         2'd0, 1'b0, 32'h00F1_0000, 6, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FFF1};

    // Reset state
    @(negedge clk_in);
    chk("rst_req", bus.dmem_req_out, 1'b0);
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_wmask", bus.dmem_wmask_out, 4'b0000);
    chk("rst_load_data", load_data_out, 32'h0);
    chk("rst_load_valid", load_valid_out, 1'b0);
    chk("rst_misaligned", misaligned_out, 1'b0);
    chk("rst_bus_err", bus_err_out, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Directed table
    foreach (tbl[i])
      run_op(tbl[i].ld, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].uns, tbl[i].rd,
             tbl[i].wt, tbl[i].ok, tbl[i].msk, tbl[i].wd, tbl[i].ld_exp);
    last_load = 32'hFFFF_FFF1;

    // Randomized ops against the reference model
    for (int r = 0; r < 40; r++) begin
      logic ld, st, uns, ok;
      logic [1:0] sz;
      logic [31:0] a, d, rd;
      int k, wt;
      k   = $urandom_range(0, 9);
      ld  = (k == 0) || (k >= 5);
      st  = (k <= 4);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      d   = $urandom;
      rd  = $urandom;
      uns = 1'($urandom_range(0, 1));
      wt  = $urandom_range(0, 6);
      ok  = aligned_m(ld, st, sz, a);
      if (ok && ld) last_load = load_m(sz, uns, a, rd);
      run_op(ld, st, a, d, sz, uns, rd, wt, ok, (ok && st) ? mask_m(sz, a) : 4'b0000,
             wdata_m(sz, d), last_load);
    end

    // An ack outside REQ is ignored
    @(negedge clk_in);
    bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = 32'hFFFF_FFFF;
    @(negedge clk_in);
    bus.dmem_ack_in = 1'b0;
    chk("stray_ack_no_req", bus.dmem_req_out, 1'b0);
    chk("stray_ack_no_load_valid", load_valid_out, 1'b0);
    chk("stray_ack_no_store_done", store_done_out, 1'b0);
    chk("stray_ack_load_held", load_data_out, last_load);

    // valid_in with neither load nor store does nothing
    @(negedge clk_in);
    valid_in = 1'b1; load_size_in = 2'd3;
    #1 chk("nop_valid_no_stall", stall_out, 1'b0);
    @(negedge clk_in);
    valid_in = 1'b0;
    chk("nop_valid_no_req", bus.dmem_req_out, 1'b0);
    chk("nop_valid_no_misaligned", misaligned_out, 1'b0);

    // Asynchronous reset during REQ
    @(negedge clk_in);
    valid_in = 1'b1; load_in = 1'b1; addr_in = 32'h0000_8000; load_size_in = 2'd2;
    @(negedge clk_in);
    valid_in = 1'b0; load_in = 1'b0;
    chk("pre_reset_req", bus.dmem_req_out, 1'b1);
    #2 rst_in = 1'b1;
    #1 chk("async_reset_req", bus.dmem_req_out, 1'b0);
    chk("async_reset_stall", stall_out, 1'b0);
    chk("async_reset_load_data", load_data_out, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    run_op(1'b1, 1'b0, 32'h0000_8004, 32'h0, 2'd2, 1'b0, 32'h5A5A_0001, 0, 1'b1, 4'b0000,
           32'h0, 32'h5A5A_0001);

    // Timeout instance: first a good load, then a load that is never acked
    @(negedge clk_in);
    valid_to = 1'b1; load_in = 1'b1; addr_in = 32'h0000_7000; load_size_in = 2'd2;
    @(negedge clk_in);
    valid_to = 1'b0; load_in = 1'b0;
    bus_to.dmem_ack_in = 1'b1; bus_to.dmem_rdata_in = 32'h1122_3344;
    @(negedge clk_in);
    bus_to.dmem_ack_in = 1'b0;
    chk("to_good_load", ld_to, 32'h1122_3344);
    @(negedge clk_in);
    valid_to = 1'b1; load_in = 1'b1; addr_in = 32'h0000_7004;
    @(negedge clk_in);
    valid_to = 1'b0; load_in = 1'b0;
    n = 0;
    while (bus_to.dmem_req_out === 1'b1 && n < 20) begin
      n++;
      @(negedge clk_in);
    end
    chk("timeout_req_cycles", n, 4);
    chk("timeout_bus_err", err_to, 1'b1);
    chk("timeout_load_valid", lv_to, 1'b1);
    chk("timeout_store_done", sd_to, 1'b0);
    chk("timeout_load_data", ld_to, 32'h0);
    chk("timeout_stall", stall_to, 1'b0);
    @(negedge clk_in);
    chk("timeout_err_one_cycle", err_to, 1'b0);
    chk("timeout_req_stays_low", bus_to.dmem_req_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
